// File: rtl/contador_pkg.sv
// Shared mode encoding for the cascaded counter and the step each mode applies to stage 0.
package contador_pkg;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DN1  = 2'b01;
    localparam logic [1:0] MODO_DN3  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    function automatic logic [1:0] paso_base(input logic [1:0] modo);
        logic [1:0] paso;
        case (modo)
            MODO_UP, MODO_DN1: paso = 2'd1;
            MODO_DN3:          paso = 2'd3;
            default:           paso = 2'd0;
        endcase
        return paso;
    endfunction

endpackage

// File: rtl/contador_etapa.sv
// One STAGE_W-bit counter slice: adds or subtracts its step, exposes the carry/borrow
// combinationally to the next slice and registers its own carry pulse.
module contador_etapa #(
    parameter int STAGE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               ld,
    input  logic               down,
    input  logic [1:0]         step,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q,
    output logic               cout,
    output logic               rco
);

    logic [STAGE_W:0] ext_q;
    logic [STAGE_W:0] ext_step;
    logic [STAGE_W:0] res;

    // One spare bit catches the carry (up) or the sign of the difference (borrow, down);
    // STAGE_W must be at least 2 so a step of 3 never borrows more than one unit.
    assign ext_q    = {1'b0, q};
    assign ext_step = {{(STAGE_W-1){1'b0}}, step};
    assign res      = down ? (ext_q - ext_step) : (ext_q + ext_step);
    assign cout     = res[STAGE_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            rco <= 1'b0;
        end else begin
            rco <= en & ~ld & cout;
            if (en) begin
                q <= ld ? d : res[STAGE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/contador_param.sv
// Fully synchronous cascaded up/down/load counter built from STAGES slices.
// Define CONT_SATURATE_EN to clamp at the full-width limits instead of wrapping.
module contador_param
    import contador_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int STAGE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enb,
    input  logic [1:0]                 modo,
    input  logic [STAGES*STAGE_W-1:0]  D,
    output logic [STAGES*STAGE_W-1:0]  Q,
    output logic [STAGES-1:0]          RCO,
    output logic                       OVF
);

    localparam int W = STAGES * STAGE_W;

    logic              load_m;
    logic              down_m;
    logic              sat;
    logic              ld_eff;
    logic [W-1:0]      d_eff;
    logic [STAGES-1:0] cout;

    assign load_m = (modo == MODO_LOAD);
    assign down_m = (modo == MODO_DN1) || (modo == MODO_DN3);

`ifdef CONT_SATURATE_EN
    // A full-width carry/borrow becomes a forced load of the limit value.
    assign sat   = enb & ~load_m & cout[STAGES-1];
    assign d_eff = sat ? (down_m ? {W{1'b0}} : {W{1'b1}}) : D;
`else
    assign sat   = 1'b0;
    assign d_eff = D;
`endif

    assign ld_eff = load_m | sat;

    for (genvar i = 0; i < STAGES; i++) begin : g_etapa
        logic [1:0] step_i;

        if (i == 0) begin : g_lsb
            assign step_i = paso_base(modo);
        end else begin : g_upper
            assign step_i = {1'b0, cout[i-1]};
        end

        contador_etapa #(
            .STAGE_W (STAGE_W)
        ) u_etapa (
            .clk   (clk),
            .reset (reset),
            .en    (enb),
            .ld    (ld_eff),
            .down  (down_m),
            .step  (step_i),
            .d     (d_eff[i*STAGE_W +: STAGE_W]),
            .q     (Q[i*STAGE_W +: STAGE_W]),
            .cout  (cout[i]),
            .rco   (RCO[i])
        );
    end

    // Sticky flag: only a real load clears it; a saturating edge sets it like a wrap does.
    always_ff @(posedge clk) begin
        if (reset) begin
            OVF <= 1'b0;
        end else if (enb) begin
            if (load_m) begin
                OVF <= 1'b0;
            end else if (cout[STAGES-1]) begin
                OVF <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: directed vector table, randomized run against a reference
// model through a scoreboard queue, and a 2-stage instance for the narrow wrap case.
module tb_contador_param;
    import contador_pkg::*;

    localparam int NS = 4;
    localparam int SW = 4;
    localparam int W  = NS * SW;
`ifdef CONT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enb;
    logic [1:0]    modo;
    logic [W-1:0]  D;
    logic [W-1:0]  Q;
    logic [NS-1:0] RCO;
    logic          OVF;

    logic          reset2, enb2;
    logic [1:0]    modo2;
    logic [7:0]    D2;
    logic [7:0]    Q2;
    logic [1:0]    RCO2;
    logic          OVF2;

    always #5 clk = ~clk;

    contador_param #(.STAGES(NS), .STAGE_W(SW)) dut (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D),
        .Q(Q), .RCO(RCO), .OVF(OVF)
    );

    contador_param #(.STAGES(2), .STAGE_W(4)) dut2 (
        .clk(clk), .reset(reset2), .enb(enb2), .modo(modo2), .D(D2),
        .Q(Q2), .RCO(RCO2), .OVF(OVF2)
    );

    typedef struct {
        logic          r;
        logic          e;
        logic [1:0]    m;
        logic [W-1:0]  d;
        logic [W-1:0]  q;
        logic [NS-1:0] rco;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0]  q;
        logic [NS-1:0] rco;
        logic          ovf;
        int            tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0]  mq;
    logic [NS-1:0] mrco;
    logic          movf;

    task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] d,
                       input logic [W-1:0] q, input logic [NS-1:0] rco, input logic ovf);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.d = d; v.q = q; v.rco = rco; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] d,
                         input exp_t ex);
        exp_t got;
        @(negedge clk);
        reset = r; enb = e; modo = m; D = d;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (Q !== got.q) begin
            errors++;
            $display("FAIL q[%0d]: got %h expected %h", got.tag, Q, got.q);
        end
        checks++;
        if (RCO !== got.rco) begin
            errors++;
            $display("FAIL rco[%0d]: got %b expected %b", got.tag, RCO, got.rco);
        end
        checks++;
        if (OVF !== got.ovf) begin
            errors++;
            $display("FAIL ovf[%0d]: got %b expected %b", got.tag, OVF, got.ovf);
        end
    endtask

    // Reference: full-width arithmetic; a stage carries when the value below its top edge
    // crosses that edge.
    task automatic model_step(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] d);
        int  stp, lim, low;
        bit  up, topc;
        logic [W:0] full;
        if (r) begin
            mq = '0; mrco = '0; movf = 1'b0;
        end else if (!e) begin
            mrco = '0;
        end else if (m == MODO_LOAD) begin
            mq = d; mrco = '0; movf = 1'b0;
        end else begin
            up  = (m == MODO_UP);
            stp = (m == MODO_DN3) ? 3 : 1;
            for (int i = 0; i < NS; i++) begin
                lim = 1 << ((i + 1) * SW);
                low = int'(mq) & (lim - 1);
                mrco[i] = up ? ((low + stp) >= lim) : (low < stp);
            end
            topc = mrco[NS-1];
            full = up ? ({1'b0, mq} + (W+1)'(stp)) : ({1'b0, mq} - (W+1)'(stp));
            if (SAT && topc) begin
                mq   = up ? {W{1'b1}} : {W{1'b0}};
                mrco = '0;
            end else begin
                mq = full[W-1:0];
            end
            if (topc) movf = 1'b1;
        end
    endtask

    task automatic check2(input int tag, input logic [7:0] q, input logic [1:0] rco, input logic ovf);
        checks++;
        if (Q2 !== q || RCO2 !== rco || OVF2 !== ovf) begin
            errors++;
            $display("FAIL two_stage[%0d]: got q=%h rco=%b ovf=%b expected q=%h rco=%b ovf=%b",
                     tag, Q2, RCO2, OVF2, q, rco, ovf);
        end
    endtask

    initial begin
        exp_t ex;
        logic r, e;
        logic [1:0] m;
        logic [W-1:0] d;

        reset = 1'b1; enb = 1'b0; modo = MODO_UP; D = '0;
        reset2 = 1'b1; enb2 = 1'b0; modo2 = MODO_UP; D2 = '0;

        //   r  e  modo       D         Q                          RCO                    OVF
        add(1, 1, MODO_UP,   16'h0000, 16'h0000,                  4'b0000,               0);
        add(0, 1, MODO_LOAD, 16'h00FE, 16'h00FE,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h00FF,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h0100,                  4'b0011,               0);
        add(0, 1, MODO_LOAD, 16'hFFFF, 16'hFFFF,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, SAT ? 16'hFFFF : 16'h0000, SAT ? 4'b0 : 4'b1111,  1);
        for (int i = 1; i <= 5; i++)
            add(0, 1, MODO_UP, 16'h0000, SAT ? 16'hFFFF : 16'(i), 4'b0000, 1);
        add(0, 1, MODO_LOAD, 16'h0002, 16'h0002,                  4'b0000,               0);
        add(0, 1, MODO_DN3,  16'h0000, SAT ? 16'h0000 : 16'hFFFF, SAT ? 4'b0 : 4'b1111,  1);
        add(0, 1, MODO_LOAD, 16'h0010, 16'h0010,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h0011,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h0012,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h0013,                  4'b0000,               0);
        add(0, 0, MODO_UP,   16'h0000, 16'h0013,                  4'b0000,               0);
        add(0, 0, MODO_DN3,  16'h0000, 16'h0013,                  4'b0000,               0);
        add(1, 1, MODO_UP,   16'h0000, 16'h0000,                  4'b0000,               0);
        add(0, 1, MODO_UP,   16'h0000, 16'h0001,                  4'b0000,               0);
        add(0, 1, MODO_DN1,  16'h0000, 16'h0000,                  4'b0000,               0);
        add(0, 1, MODO_DN1,  16'h0000, SAT ? 16'h0000 : 16'hFFFF, SAT ? 4'b0 : 4'b1111,  1);
        add(0, 0, MODO_UP,   16'h0000, SAT ? 16'h0000 : 16'hFFFF, 4'b0000,               1);
        add(0, 1, MODO_LOAD, 16'h0100, 16'h0100,                  4'b0000,               0);
        add(0, 1, MODO_DN1,  16'h0000, 16'h00FF,                  4'b0011,               0);
        add(0, 1, MODO_DN3,  16'h0000, 16'h00FC,                  4'b0000,               0);
        add(1, 1, MODO_LOAD, 16'hABCD, 16'h0000,                  4'b0000,               0);

        foreach (vecs[i]) begin
            ex.q = vecs[i].q; ex.rco = vecs[i].rco; ex.ovf = vecs[i].ovf; ex.tag = i;
            apply(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].d, ex);
        end

        for (int i = 0; i < 400; i++) begin
            r = (i == 0) || ($urandom_range(0, 31) == 0);
            e = ($urandom_range(0, 7) != 0);
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       d = 16'hFFFF - 16'($urandom_range(0, 3));
                1:       d = 16'($urandom_range(0, 3));
                2:       d = {4'($urandom), 12'hFFF - 12'($urandom_range(0, 2))};
                default: d = 16'($urandom);
            endcase
            model_step(r, e, m, d);
            ex.q = mq; ex.rco = mrco; ex.ovf = movf; ex.tag = 1000 + i;
            apply(r, e, m, d, ex);
        end

        @(negedge clk);
        reset2 = 1'b1; enb2 = 1'b1; modo2 = MODO_UP;
        @(negedge clk);
        check2(0, 8'h00, 2'b00, 1'b0);
        reset2 = 1'b0; modo2 = MODO_LOAD; D2 = 8'hFD;
        @(negedge clk);
        check2(1, 8'hFD, 2'b00, 1'b0);
        modo2 = MODO_UP;
        @(negedge clk);
        check2(2, 8'hFE, 2'b00, 1'b0);
        @(negedge clk);
        check2(3, 8'hFF, 2'b00, 1'b0);
        @(negedge clk);
        check2(4, SAT ? 8'hFF : 8'h00, SAT ? 2'b00 : 2'b11, 1'b1);
        enb2 = 1'b0;
        @(negedge clk);
        check2(5, SAT ? 8'hFF : 8'h00, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 The block SHALL have parameter STAGES, default 4, giving the number of cascaded counter stages (range 1-8).
REQ-002 The block SHALL have parameter STAGE_W, default 4, giving the width in bits of each stage; total width W = STAGES*STAGE_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enb, input, 1 bit: count/load enable.
REQ-006 The block SHALL have port modo, input, 2 bits: operating mode.
REQ-007 The block SHALL have port D, input, W bits: parallel load value.
REQ-008 The block SHALL have port Q, output, W bits: registered count value.
REQ-009 The block SHALL have port RCO, output, STAGES bits: registered per-stage carry/borrow pulses.
REQ-010 The block SHALL have port OVF, output, 1 bit: sticky full-width overflow/underflow flag.

Function
REQ-011 The block SHALL decode modo as follows: 00 = up by 1, 01 = down by 1, 10 = down by 3, 11 = load D.
REQ-012 All stages SHALL share clk and be fully synchronous, with carry/borrow propagated combinationally between stages and no ripple clocking.
REQ-013 When enb=1, Q SHALL update on the next clk edge per modo; latency is 1 cycle.
REQ-014 When enb=0, Q and OVF SHALL hold, and RCO SHALL be 0 on the next edge.
REQ-015 Arithmetic SHALL be modulo 2^W: up from all-ones gives 0; down-1 from 0 gives all-ones; down-3 from 0/1/2 gives 2^W-3, 2^W-2, 2^W-1 respectively.
REQ-016 RCO[i] SHALL be 1 for exactly one cycle, in the cycle following an enabled count in which stage i produced a carry (up) or borrow (down) out of its MSB; otherwise it SHALL be 0.
REQ-017 In load mode, Q SHALL take D, RCO SHALL be all 0, and OVF SHALL be cleared on that edge.
REQ-018 OVF SHALL be set on the edge where the top stage produces carry/borrow (or saturation occurs, see REQ-022), and SHALL remain set until reset or a load.
REQ-019 If the top stage carries and a load occurs on the same edge, the load SHALL win: OVF=0 and Q=D.

Reset
REQ-020 When reset=1 at a clk edge, the block SHALL set Q=0, RCO=0 and OVF=0, taking priority over enb and modo, including mid-count.
REQ-021 Counting SHALL resume from 0 on the first edge after reset deasserts with enb=1.

Configuration
REQ-022 When macro CONT_SATURATE_EN is defined, up/down modes SHALL saturate instead of wrapping: up holds at all-ones and down-1/down-3 clamp at 0. On a saturating edge, RCO SHALL be all 0 and OVF SHALL be set.
REQ-023 When CONT_SATURATE_EN is undefined, the block SHALL use the wrap behaviour of REQ-015/REQ-016.

Structure
REQ-024 Package contador_pkg SHALL hold the mode constants MODO_UP=2'b00, MODO_DN1=2'b01, MODO_DN3=2'b10 and MODO_LOAD=2'b11.
REQ-025 One STAGE_W-bit stage SHALL be sub-module contador_etapa, with carry-in/borrow-in, carry-out/borrow-out, load and enable; contador_param SHALL instantiate it STAGES times with a generate loop.
REQ-026 Only stage 0 SHALL apply the step of 1 or 3; higher stages SHALL step by their carry/borrow-in.

Verification
REQ-027 With defaults, reset=1, enb=1, modo=00: after one edge Q=0x0000, RCO=4'b0000, OVF=0.
REQ-028 Load D=0x00FE, then modo=00 for two edges: Q=0x00FF, then 0x0100 with RCO=4'b0011 one cycle later, OVF=0.
REQ-029 Load 0xFFFF, then up one edge: Q=0x0000, RCO=4'b1111, OVF=1, and OVF holds through 5 further counts. With CONT_SATURATE_EN: Q=0xFFFF, RCO=4'b0000, OVF=1.
REQ-030 Load 0x0002, then modo=10 one edge: Q=0xFFFF, RCO=4'b1111, OVF=1. With CONT_SATURATE_EN: Q=0x0000.
REQ-031 Count up from 0x0010 for 3 edges, then enb=0 for 2 edges, then reset=1 one edge: Q=0x0013, held at 0x0013, then 0x0000 with OVF=0.
REQ-032 With STAGES=2, load 0xFD, then up 3 edges: Q=0xFE, 0xFF, 0x00, with RCO=2'b11 after the wrap and OVF=1.
